// File: rtl/sd_block_read.sv
// sd_block_read: SPI-mode SD single-block reader (CMD17).
// Issues CMD17 for a block, waits for R1 and the 0xFE start token, then
// streams the 512 data bytes out on rd_data/rd_vld. It ends with a one-cycle
// sd_read_ok or sd_read_err pulse.
// Optional build macro SD_BYTE_ADDR_EN: the CMD17 argument becomes
// blk_addr*512 for byte-addressed SDSC cards. Otherwise blk_addr is passed
// unchanged, which suits block-addressed SDHC/SDXC cards.
`timescale 1ns/1ps
module sd_block_read #(
  parameter int CLK_DIV       = 4,
  parameter int RESP_TIMEOUT  = 8,
  parameter int TOKEN_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_ok,
  input  logic        sd_ren,
  input  logic [31:0] blk_addr,
  output logic        sd_ck,
  output logic        sd_csn,
  output logic        sd_mosi,
  input  logic        sd_miso,
  output logic [7:0]  rd_data,
  output logic        rd_vld,
  output logic        sd_read_ok,
  output logic        sd_read_err,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC,
    S_FINISH, S_ERR, S_DONE_OK, S_DONE_ERR
  } state_t;

  state_t      state;
  logic [15:0] div_cnt;   // clk cycles within one sd_ck half-period
  logic [3:0]  edge_cnt;  // sd_ck edge index within a byte (even = rise)
  logic [6:0]  tx_sh;     // remaining bits of the byte being sent
  logic [6:0]  rx_sh;     // bits received so far in the current byte
  logic [7:0]  rx_byte;   // last complete received byte
  logic [15:0] cnt;       // byte / poll counter of the current state
  logic [31:0] arg;
  logic [7:0]  cmd_next;
  logic        half_done;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] a);
    case (idx)
      3'd0:    cmd_byte = 8'h51;
      3'd1:    cmd_byte = a[31:24];
      3'd2:    cmd_byte = a[23:16];
      3'd3:    cmd_byte = a[15:8];
      3'd4:    cmd_byte = a[7:0];
      default: cmd_byte = 8'hFF;
    endcase
  endfunction

  // Command byte that follows the one currently on the wire
  always_comb cmd_next = cmd_byte(cnt[2:0] + 3'd1, arg);

  assign half_done = (div_cnt == 16'(CLK_DIV - 1));

  // Transaction FSM with the SPI byte engine; all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sd_ck       <= 1'b0;
      sd_csn      <= 1'b1;
      sd_mosi     <= 1'b1;
      rd_data     <= 8'h00;
      rd_vld      <= 1'b0;
      sd_read_ok  <= 1'b0;
      sd_read_err <= 1'b0;
      busy        <= 1'b0;
      div_cnt     <= '0;
      edge_cnt    <= '0;
      tx_sh       <= '1;
      rx_sh       <= '0;
      rx_byte     <= '1;
      cnt         <= '0;
      arg         <= '0;
    end else begin
      rd_vld      <= 1'b0;
      sd_read_ok  <= 1'b0;
      sd_read_err <= 1'b0;
      case (state)
        S_IDLE: begin
          sd_csn  <= 1'b1;
          sd_ck   <= 1'b0;
          sd_mosi <= 1'b1;
          // busy is checked so the terminating pulse cycle cannot accept
          if (sd_ren && init_ok && !busy) begin
`ifdef SD_BYTE_ADDR_EN
            arg <= {blk_addr[22:0], 9'b0};
`else
            arg <= blk_addr;
`endif
            state    <= S_CMD;
            busy     <= 1'b1;
            sd_csn   <= 1'b0;
            sd_mosi  <= 1'b0;      // MSB of 0x51 ready before the first rise
            tx_sh    <= 7'h51;
            div_cnt  <= '0;
            edge_cnt <= '0;
            cnt      <= '0;
          end else begin
            busy <= 1'b0;
          end
        end
        S_DONE_OK: begin
          sd_read_ok <= 1'b1;
          state      <= S_IDLE;
        end
        S_DONE_ERR: begin
          sd_read_err <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          if (!half_done) begin
            div_cnt <= div_cnt + 16'd1;
          end else begin
            div_cnt  <= '0;
            sd_ck    <= ~sd_ck;
            edge_cnt <= edge_cnt + 4'd1;
            if (!sd_ck) begin
              // Rising edge: sample MISO; the eighth rise completes a byte
              rx_sh <= {rx_sh[5:0], sd_miso};
              if (edge_cnt == 4'd14) begin
                rx_byte <= {rx_sh, sd_miso};
                if (state == S_DATA) begin
                  rd_data <= {rx_sh, sd_miso};
                  rd_vld  <= 1'b1;
                end
              end
            end else if (edge_cnt != 4'd15) begin
              // Falling edge inside a byte: present the next MOSI bit
              sd_mosi <= tx_sh[6];
              tx_sh   <= {tx_sh[5:0], 1'b1};
            end else begin
              // Falling edge ending a byte: decide what the next byte is.
              // Every byte except command bytes is 0xFF.
              sd_mosi <= 1'b1;
              tx_sh   <= '1;
              case (state)
                S_CMD: begin
                  if (cnt == 16'd5) begin
                    state <= S_R1;
                    cnt   <= '0;
                  end else begin
                    cnt     <= cnt + 16'd1;
                    sd_mosi <= cmd_next[7];
                    tx_sh   <= cmd_next[6:0];
                  end
                end
                S_R1: begin
                  if (rx_byte == 8'h00) begin
                    state <= S_TOKEN;
                    cnt   <= '0;
                  end else if (rx_byte != 8'hFF || cnt == 16'(RESP_TIMEOUT - 1)) begin
                    state  <= S_ERR;
                    sd_csn <= 1'b1;
                  end else begin
                    cnt <= cnt + 16'd1;
                  end
                end
                S_TOKEN: begin
                  if (rx_byte == 8'hFE) begin
                    state <= S_DATA;
                    cnt   <= '0;
                  end else if (rx_byte != 8'hFF || cnt == 16'(TOKEN_TIMEOUT - 1)) begin
                    state  <= S_ERR;
                    sd_csn <= 1'b1;
                  end else begin
                    cnt <= cnt + 16'd1;
                  end
                end
                S_DATA: begin
                  if (cnt == 16'd511) begin
                    state <= S_CRC;
                    cnt   <= '0;
                  end else begin
                    cnt <= cnt + 16'd1;
                  end
                end
                S_CRC: begin
                  if (cnt == 16'd1) begin
                    state  <= S_FINISH;
                    sd_csn <= 1'b1;
                  end else begin
                    cnt <= cnt + 16'd1;
                  end
                end
                S_FINISH: state <= S_DONE_OK;
                S_ERR:    state <= S_DONE_ERR;
                default:  state <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_read.sv
// tb_sd_block_read: randomized scoreboard bench for sd_block_read with a
// byte-level SPI card model.
`timescale 1ns/1ps
module tb_sd_block_read;
  localparam int CD = 2;
  localparam int RT = 8;
  localparam int TT = 1024;
  localparam int NRESP = 2048;

  logic        clk = 1'b0;
  logic        rst, init_ok, sd_ren;
  logic [31:0] blk_addr;
  logic        sd_ck, sd_csn, sd_mosi;
  logic        sd_miso = 1'b1;
  logic [7:0]  rd_data;
  logic        rd_vld, sd_read_ok, sd_read_err, busy;

  sd_block_read #(.CLK_DIV(CD), .RESP_TIMEOUT(RT), .TOKEN_TIMEOUT(TT)) dut (
    .clk(clk), .rst(rst), .init_ok(init_ok), .sd_ren(sd_ren), .blk_addr(blk_addr),
    .sd_ck(sd_ck), .sd_csn(sd_csn), .sd_mosi(sd_mosi), .sd_miso(sd_miso),
    .rd_data(rd_data), .rd_vld(rd_vld), .sd_read_ok(sd_read_ok),
    .sd_read_err(sd_read_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- card model ----------------
  logic [7:0] resp [NRESP];  // byte the card returns at index i after CS falls
  logic [7:0] mosi_q[$];     // bytes the card received while selected
  int         card_bytes = 0;
  int         c_idx = 0, c_bit = 0;
  logic [7:0] c_cur = 8'hFF, c_rx = 8'h00;
  logic       prev_ck = 1'b0, prev_csn = 1'b1;

  always @(sd_ck, sd_csn) begin
    if (sd_csn !== prev_csn) begin
      if (sd_csn === 1'b0) begin
        c_idx = 0; c_bit = 0; card_bytes = 0;
        c_cur = resp[0];
        sd_miso = c_cur[7];
      end else begin
        sd_miso = 1'b1;
      end
      prev_csn = sd_csn;
    end
    if (sd_ck !== prev_ck) begin
      if (sd_csn === 1'b0) begin
        if (sd_ck === 1'b1) begin
          c_rx = {c_rx[6:0], sd_mosi};
          c_bit++;
          if (c_bit == 8) begin
            mosi_q.push_back(c_rx);
            card_bytes++;
          end
        end else begin
          if (c_bit == 8) begin
            c_idx++;
            c_bit = 0;
            c_cur = (c_idx < NRESP) ? resp[c_idx] : 8'hFF;
            sd_miso = c_cur[7];
          end else begin
            sd_miso = c_cur[7 - c_bit];
          end
        end
      end
      prev_ck = sd_ck;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    bit ok;
    int nbytes;  // bytes clocked with CS low
    int acc;     // accept cycle
  } txn_t;

  txn_t       exp_res[$];
  logic [7:0] exp_data[$];
  logic [7:0] exp_cmd[$];
  int         acc_now = 0;
  bit         rise_pending = 0;

  // Walk the card's reply stream with the protocol rules
  task automatic model(output bit ok, output int nb, output int ds);
    int idx;
    bit got;
    logic [7:0] b;
    idx = 6; got = 0; ok = 0; ds = 0; b = 8'hFF;
    for (int p = 0; p < RT && !got; p++) begin
      b = resp[idx]; idx++;
      if (b != 8'hFF) got = 1;
    end
    nb = idx;
    if (!got || b != 8'h00) return;
    for (int p = 0; p < TT; p++) begin
      b = resp[idx]; idx++;
      nb = idx;
      if (b == 8'hFE) begin
        ok = 1; ds = idx; nb = idx + 514;
        return;
      end else if (b != 8'hFF) begin
        return;
      end
    end
  endtask

  // Lay out the card reply: 6 filler, polls, R1, polls, token, data, CRC
  task automatic fill(input int r1_ff, input logic [7:0] r1, input int tok_ff,
                      input bit with_data, input bit ramp);
    int i;
    for (int k = 0; k < NRESP; k++) resp[k] = 8'hFF;
    i = 6 + r1_ff;
    resp[i] = r1; i++;
    if (with_data) begin
      i += tok_ff;
      resp[i] = 8'hFE; i++;
      for (int k = 0; k < 512; k++) resp[i + k] = ramp ? 8'(k) : 8'($urandom);
      i += 512;
      resp[i] = 8'($urandom); resp[i + 1] = 8'($urandom);
    end
  endtask

  task automatic issue(input logic [31:0] addr);
    bit ok; int nb, ds;
    logic [31:0] a;
    txn_t t;
    model(ok, nb, ds);
`ifdef SD_BYTE_ADDR_EN
    a = addr * 32'd512;
`else
    a = addr;
`endif
    exp_cmd.push_back(8'h51);
    exp_cmd.push_back(a[31:24]); exp_cmd.push_back(a[23:16]);
    exp_cmd.push_back(a[15:8]);  exp_cmd.push_back(a[7:0]);
    exp_cmd.push_back(8'hFF);
    if (ok) for (int k = 0; k < 512; k++) exp_data.push_back(resp[ds + k]);
    @(negedge clk);
    t.ok = ok; t.nbytes = nb; t.acc = cyc;
    exp_res.push_back(t);
    acc_now = cyc;
    rise_pending = 1;
    blk_addr = addr;
    sd_ren = 1'b1;
    @(negedge clk);
    sd_ren = 1'b0;
    blk_addr = $urandom;
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_res.size() == 0) done = 1;
    end
    if (!done) fail_now({name, " timeout"});
  endtask

  task automatic wait_data(input int n, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (data_cnt >= n) done = 1;
    end
    if (!done) fail_now("wait_data timeout");
  endtask

  int data_cnt = 0;
  int last_vld = -1;

  // Monitor: pops expectations whenever the DUT presents output
  always @(negedge clk) begin
    if (rst) begin
      data_cnt = 0;
      last_vld = -1;
    end else begin
      while (mosi_q.size() > 0) begin
        logic [7:0] b;
        b = mosi_q.pop_front();
        if (exp_cmd.size() > 0) check("mosi_cmd", b, exp_cmd.pop_front());
        else check("mosi_fill", b, 8'hFF);
      end
      if (rise_pending && sd_ck) begin
        check("first_rise", cyc - acc_now, 1 + CD);
        rise_pending = 0;
      end
      if (rd_vld) begin
        if (exp_data.size() == 0) fail_now("unexpected rd_vld");
        else check("rd_data", rd_data, exp_data.pop_front());
        if (last_vld >= 0) check("vld_gap", cyc - last_vld, 16 * CD);
        last_vld = cyc;
        data_cnt++;
      end
      if (sd_read_ok || sd_read_err) begin
        if (exp_res.size() == 0) begin
          fail_now("unexpected pulse");
        end else begin
          txn_t t;
          t = exp_res.pop_front();
          check("pulse_kind", {sd_read_ok, sd_read_err}, t.ok ? 2'b10 : 2'b01);
          check("data_count", data_cnt, t.ok ? 512 : 0);
          check("csn_bytes", card_bytes, t.nbytes);
          check("latency", cyc - t.acc, (t.nbytes + 1) * 16 * CD + 2);
          check("busy_in_pulse", busy, 1'b1);
        end
        data_cnt = 0;
        last_vld = -1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    rst = 1'b1; init_ok = 1'b0; sd_ren = 1'b0; blk_addr = '0;
    for (int k = 0; k < NRESP; k++) resp[k] = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_ck", sd_ck, 1'b0);
    check("rst_csn", sd_csn, 1'b1);
    check("rst_mosi", sd_mosi, 1'b1);
    check("rst_data", rd_data, 8'h00);
    check("rst_vld", rd_vld, 1'b0);
    check("rst_pulses", {sd_read_ok, sd_read_err}, 2'b00);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Request while the card is not initialised is ignored
    sd_ren = 1'b1; blk_addr = 32'h5;
    @(negedge clk);
    sd_ren = 1'b0;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (!sd_csn || busy || sd_ck) seen = 1;
    end
    check("noinit_idle", seen, 1'b0);

    // Successful read, first-poll R1/token, ramp data; extra request mid-DATA
    init_ok = 1'b1;
    fill(0, 8'h00, 0, 1, 1);
    issue(32'h12);
    wait_data(50, 8000);
    init_ok = 1'b0;  // falling init_ok must not disturb the transfer
    sd_ren = 1'b1; blk_addr = 32'h77;
    @(negedge clk);
    sd_ren = 1'b0;
    wait_idle(20000, "read_ok");
    init_ok = 1'b1;

    // R1 error after a few idle polls
    fill($urandom_range(0, 3), 8'h05, 0, 0, 0);
    issue($urandom);
    wait_idle(2000, "r1_err");
    check("r1err_csn", sd_csn, 1'b1);
    check("r1err_busy", busy, 1'b0);

    // R1 never arrives
    fill(RT + 4, 8'hFF, 0, 0, 0);
    issue($urandom);
    wait_idle(2000, "r1_timeout");

    // Token never arrives: 1024 polls then error
    fill(0, 8'h00, 0, 0, 0);
    issue(32'h0000_0400);
    wait_idle(36000, "token_timeout");
    check("tok_csn", sd_csn, 1'b1);

    // Reset during DATA byte 100
    fill(0, 8'h00, 0, 1, 0);
    issue(32'hABCD);
    wait_data(100, 8000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_csn", sd_csn, 1'b1);
    check("midrst_ck", sd_ck, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_pulse", {sd_read_ok, sd_read_err, rd_vld}, 3'b000);
    rst = 1'b0;
    exp_res.delete(); exp_data.delete(); exp_cmd.delete(); mosi_q.delete();
    rise_pending = 0;
    repeat (50) @(negedge clk);
    check("midrst_idle", {sd_csn, busy}, 2'b10);

    // Randomized read after reset completes normally
    fill($urandom_range(0, RT - 1), 8'h00, $urandom_range(0, 40), 1, 0);
    issue($urandom);
    wait_idle(22000, "read_after_rst");
    check("final_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
